// File: rtl/complex_vec_loader.sv
// complex_vec_loader: packs SIZE complex operand pairs into one wide vector.
// Ping-pong double buffer; short vectors are zero padded.
// Ports:
//   clk_i, rst_ni    clock, async active-low reset
//   flush_i          sync clear of all buffered state
//   in_valid_i/in_ready_o/in_data_i/in_last_i   narrow pair stream
//   out_valid_o/out_ready_i/out_operands_o      wide vector stream
//   busy_o           any vector held or partially loaded
module complex_vec_loader #(
  parameter int SIZE = 16,
  parameter int DW   = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [3:0][DW-1:0]          in_data_i,
  input  logic                        in_last_i,
  output logic [SIZE*4-1:0][DW-1:0]   out_operands_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        busy_o
);

  localparam int CW = $clog2(SIZE);

  logic [3:0][DW-1:0] mem_q [2][SIZE];
  logic [SIZE-1:0]    mask_q [2];
  logic [1:0]         full_q;
  logic               wr_sel;
  logic               rd_sel;
  logic [CW-1:0]      cnt_q;

  logic in_acc;
  logic out_acc;
  logic close;

  assign in_ready_o  = !flush_i && !full_q[wr_sel];
  assign out_valid_o = !flush_i && full_q[rd_sel];
  assign in_acc      = in_valid_i && in_ready_o;
  assign out_acc     = out_valid_o && out_ready_i;
  assign close       = (cnt_q == CW'(SIZE-1)) || in_last_i;

  assign busy_o = |full_q || (cnt_q != '0) || (|mask_q[wr_sel]);

  // Empty slots read as +0.0 so padding adds nothing downstream.
  for (genvar g = 0; g < SIZE; g++) begin : g_slot
    assign out_operands_o[4*g +: 4] =
      mask_q[rd_sel][g] ? mem_q[rd_sel][g] : '0;
  end

  // Data words need no reset; the masks gate them.
  always_ff @(posedge clk_i) begin
    if (in_acc) begin
      mem_q[wr_sel][cnt_q] <= in_data_i;
    end
  end

  // A drain always targets the other buffer from a fill, since a
  // fill needs full[wr_sel]=0 and a drain needs full[rd_sel]=1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q    <= '0;
      mask_q[0] <= '0;
      mask_q[1] <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      cnt_q     <= '0;
    end else if (flush_i) begin
      full_q    <= '0;
      mask_q[0] <= '0;
      mask_q[1] <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (in_acc) begin
        mask_q[wr_sel][cnt_q] <= 1'b1;
        if (close) begin
          full_q[wr_sel] <= 1'b1;
          wr_sel         <= !wr_sel;
          cnt_q          <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
      if (out_acc) begin
        full_q[rd_sel] <= 1'b0;
        mask_q[rd_sel] <= '0;
        rd_sel         <= !rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_complex_vec_loader.sv
// tb_complex_vec_loader: directed and random stream checks
// against a queue-based vector model.
module tb_complex_vec_loader;

  localparam int SIZE = 16;
  localparam int DW   = 64;
  localparam int NW   = SIZE * 4;

  typedef logic [NW-1:0][DW-1:0] vec_t;
  typedef logic [3:0][DW-1:0]    beat_t;

  logic  clk_i = 1'b0;
  logic  rst_ni = 1'b0;
  logic  flush_i = 1'b0;
  logic  in_valid_i = 1'b0;
  logic  in_last_i = 1'b0;
  logic  out_ready_i = 1'b0;
  beat_t in_data_i = '0;
  logic  in_ready_o;
  logic  out_valid_o;
  logic  busy_o;
  vec_t  out_operands_o;

  always #5 clk_i = ~clk_i;

  complex_vec_loader #(.SIZE(SIZE), .DW(DW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data_i),
    .in_last_i      (in_last_i),
    .out_operands_o (out_operands_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .busy_o         (busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Model: queue of completed vectors (max two held) + partial vector.
  vec_t mq[$];
  vec_t cur;
  int   cur_n;
  bit   acc_in;
  int   n_out;
  int   cyc;

  function automatic bit m_ready();
    return !flush_i && mq.size() < 2;
  endfunction

  function automatic bit m_valid();
    return !flush_i && mq.size() > 0;
  endfunction

  function automatic bit m_busy();
    return mq.size() > 0 || cur_n > 0;
  endfunction

  task automatic model_clear();
    mq.delete();
    cur   = '0;
    cur_n = 0;
  endtask

  function automatic beat_t seq_beat(input int i);
    beat_t b;
    for (int k = 0; k < 4; k++) b[k] = DW'(i * 4 + k);
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    for (int k = 0; k < 4; k++) b[k] = {$urandom, $urandom};
    return b;
  endfunction

  // One clock: check outputs mid-cycle, then advance model at the edge.
  task automatic cycle();
    bit ai;
    bit ao;
    #1;
    chk("in_ready", DW'(in_ready_o), DW'(m_ready()));
    chk("out_valid", DW'(out_valid_o), DW'(m_valid()));
    chk("busy", DW'(busy_o), DW'(m_busy()));
    if (m_valid()) begin
      for (int j = 0; j < NW; j++)
        chk("operand", out_operands_o[j], mq[0][j]);
    end
    ai = in_valid_i && m_ready();
    ao = m_valid() && out_ready_i;
    @(posedge clk_i);
    #1;
    cyc++;
    if (flush_i) begin
      model_clear();
    end else begin
      if (ao) begin
        void'(mq.pop_front());
        n_out++;
      end
      if (ai) begin
        for (int k = 0; k < 4; k++) cur[4*cur_n+k] = in_data_i[k];
        cur_n++;
        if (cur_n == SIZE || in_last_i) begin
          mq.push_back(cur);
          cur   = '0;
          cur_n = 0;
        end
      end
    end
    acc_in = ai;
  endtask

  task automatic send(input beat_t d, input bit last);
    int guard;
    guard      = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    do begin
      cycle();
      guard++;
    end while (!acc_in && guard < 200);
    if (!acc_in) chk("send_timeout", 64'd0, 64'd1);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t sb [3];
    int    c0;
    model_clear();
    n_out = 0;
    cyc   = 0;

    // Reset state
    #12;
    chk("rst_in_ready", DW'(in_ready_o), 64'd1);
    chk("rst_out_valid", DW'(out_valid_o), 64'd0);
    chk("rst_busy", DW'(busy_o), 64'd0);
    for (int j = 0; j < NW; j++)
      chk("rst_operand", out_operands_o[j], 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Full vector, taken immediately
    out_ready_i = 1'b1;
    for (int i = 0; i < SIZE; i++) send(seq_beat(i), i == SIZE - 1);
    #1;
    chk("full_valid", DW'(out_valid_o), 64'd1);
    for (int j = 0; j < NW; j++)
      chk("full_word", out_operands_o[j], DW'(j));
    cycle();
    chk("full_taken", DW'(out_valid_o), 64'd0);
    idle(2);

    // Short vector, zero padded
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb[i] = rnd_beat();
      send(sb[i], i == 2);
    end
    #1;
    chk("short_valid", DW'(out_valid_o), 64'd1);
    chk("short_w0", out_operands_o[0], sb[0][0]);
    chk("short_w11", out_operands_o[11], sb[2][3]);
    for (int j = 12; j < NW; j++)
      chk("short_pad", out_operands_o[j], 64'd0);
    out_ready_i = 1'b1;
    idle(2);

    // Back-pressure: two vectors held, input stalls
    out_ready_i = 1'b0;
    for (int i = 0; i < 2 * SIZE; i++)
      send(seq_beat(i), 1'b0);
    chk("bp_in_ready", DW'(in_ready_o), 64'd0);
    chk("bp_busy", DW'(busy_o), 64'd1);
    out_ready_i = 1'b1;
    cycle();
    out_ready_i = 1'b0;
    chk("bp_ready_back", DW'(in_ready_o), 64'd1);
    chk("bp_valid_b", DW'(out_valid_o), 64'd1);
    chk("bp_b_w0", out_operands_o[0], 64'd64);
    chk("bp_b_w63", out_operands_o[63], 64'd127);
    idle(2);
    out_ready_i = 1'b1;
    idle(2);

    // Ping-pong: 64 beats, no bubbles
    n_out = 0;
    c0    = cyc;
    for (int i = 0; i < 4 * SIZE; i++)
      send(rnd_beat(), (i % SIZE) == SIZE - 1);
    chk("pp_cycles", DW'(cyc - c0), DW'(4 * SIZE));
    idle(2);
    chk("pp_outs", DW'(n_out), 64'd4);

    // Flush with one pending and one partial vector
    out_ready_i = 1'b0;
    for (int i = 0; i < SIZE + 5; i++) send(rnd_beat(), 1'b0);
    flush_i = 1'b1;
    #1;
    chk("fl_valid", DW'(out_valid_o), 64'd0);
    chk("fl_ready", DW'(in_ready_o), 64'd0);
    cycle();
    flush_i = 1'b0;
    chk("fl_busy", DW'(busy_o), 64'd0);
    out_ready_i = 1'b1;
    for (int i = 0; i < SIZE; i++) send(seq_beat(i + 100), 1'b0);
    #1;
    chk("fl_new_w0", out_operands_o[0], 64'd400);
    idle(2);

    // Async reset mid-fill
    out_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) send(rnd_beat(), 1'b0);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("ar_ready", DW'(in_ready_o), 64'd1);
    chk("ar_valid", DW'(out_valid_o), 64'd0);
    chk("ar_busy", DW'(busy_o), 64'd0);
    model_clear();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid_i  = ($urandom % 4) != 0;
      in_data_i   = rnd_beat();
      in_last_i   = ($urandom % 8) == 0;
      out_ready_i = ($urandom % 3) != 0;
      flush_i     = ($urandom % 100) == 0;
      cycle();
    end
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
